// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller/datapath pair.
// Holds the control-field encodings, opcode/funct constants and the ALU operation enum.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// Register $0 is never written and always reads zero.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    // Register array: async clear, write port ignores $0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mips_mc_datapath.sv
// Multi-cycle MIPS datapath: PC/IR/MDR/A/B/ALUOut state, register file and ALU,
// stepped one micro-operation per clock by the main controller's enables.
module mips_mc_datapath
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        IorD,
    input  logic        RegDst,
    input  logic        MemtoReg,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  ALUOp,
    input  logic        PCSrc,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        Zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out
);

    logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] src_a, src_b, alu_result, imm_ext, wb_data;
    logic [4:0]  wb_reg;
    alu_op_e     alu_ctl;

    assign imm_ext = sign_ext(ir[15:0]);
    assign wb_reg  = RegDst ? ir[15:11] : ir[20:16];
    assign wb_data = MemtoReg ? mdr : alu_out;

    mips_regfile u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (RegWrite),
        .raddr1 (ir[25:21]),
        .raddr2 (ir[20:16]),
        .waddr  (wb_reg),
        .wdata  (wb_data),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // ALU operand selection
    always_comb begin
        src_a = ALUSrcA ? a_reg : pc;
        src_b = b_reg;
        case (ALUSrcB)
            SRCB_B:      src_b = b_reg;
            SRCB_FOUR:   src_b = 32'd4;
            SRCB_IMM:    src_b = imm_ext;
            SRCB_IMM_SH: src_b = {imm_ext[29:0], 2'b00};
            default:     src_b = b_reg;
        endcase
    end

    // ALU control: reserved ALUOp and unknown Funct both fall back to add
    always_comb begin
        alu_ctl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (ir[5:0])
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    // ALU datapath, 32-bit wrapping arithmetic
    always_comb begin
        alu_result = src_a + src_b;
        case (alu_ctl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
            default: alu_result = src_a + src_b;
        endcase
    end

    // Architectural state: free-running capture registers plus enabled PC/IR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
        end else begin
            mdr     <= mem_rdata;
            a_reg   <= rf_rdata1;
            b_reg   <= rf_rdata2;
            alu_out <= alu_result;
            if (IRWrite) begin
                ir <= mem_rdata;
            end
            if (PCWrite) begin
                pc <= PCSrc ? alu_out : alu_result;
            end
        end
    end

    assign Opcode    = ir[31:26];
    assign Funct     = ir[5:0];
    assign Zero      = (alu_result == 32'd0);
    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_we    = MemWrite;
    assign pc_out    = pc;

endmodule

// File: tb/tb_mips_mc_datapath.sv
// Self-checking bench for mips_mc_datapath: drives controller micro-steps and
// compares against a register/PC model kept as plain arrays and arithmetic.
module tb_mips_mc_datapath;

    logic        clk, rst_n;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, IorD, RegDst, MemtoReg, ALUSrcA, PCSrc;
    logic [1:0]  ALUSrcB, ALUOp;
    logic [5:0]  Opcode, Funct;
    logic        Zero, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf_m [32];
    logic [31:0] pc_m;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [9];

    mips_mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
        IorD = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0; ALUSrcA = 1'b0;
        ALUSrcB = 2'b00; ALUOp = 2'b00; PCSrc = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] instr);
        idle();
        IorD = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b01; ALUOp = 2'b00;
        PCSrc = 1'b0; PCWrite = 1'b1; IRWrite = 1'b1;
        mem_rdata = instr;
        #1 check("fetch_addr", mem_addr, pc_m);
        step();
        pc_m = pc_m + 32'd4;
        idle();
        check("opcode", {26'd0, Opcode}, {26'd0, instr[31:26]});
        check("pc_after_fetch", pc_out, pc_m);
    endtask

    task automatic decode();
        idle();
        ALUSrcB = 2'b11;
        step();
        idle();
    endtask

    task automatic run_addi(input int rt, input int rs, input logic [15:0] imm);
        logic [31:0] instr;
        logic [31:0] exp;
        instr = {6'h08, rs[4:0], rt[4:0], imm};
        exp = rf_m[rs] + {{16{imm[15]}}, imm};
        fetch(instr);
        decode();
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b00;
        step();
        idle();
        RegDst = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b1;
        step();
        idle();
        if (rt != 0) rf_m[rt] = exp;
    endtask

    task automatic run_r(input int rd, input int rs, input int rt, input logic [5:0] f);
        logic [31:0] instr;
        logic [31:0] exp;
        instr = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, f};
        exp = ref_alu(f, rf_m[rs], rf_m[rt]);
        fetch(instr);
        check("funct", {26'd0, Funct}, {26'd0, f});
        decode();
        ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = 2'b10;
        #1 check("zero", {31'd0, Zero}, {31'd0, (exp == 32'd0)});
        step();
        idle();
        RegDst = 1'b1; MemtoReg = 1'b0; RegWrite = 1'b1; IorD = 1'b1;
        #1 check("aluout_addr", mem_addr, exp);
        step();
        idle();
        if (rd != 0) rf_m[rd] = exp;
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        idle();
        mem_rdata = {6'h00, 5'd0, r[4:0], 16'h0000};
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        step();
        v = mem_wdata;
    endtask

    task automatic check_reg(input string name, input int r);
        logic [31:0] v;
        read_reg(r, v);
        check(name, v, rf_m[r]);
    endtask

    // Build an arbitrary 32-bit value: load upper half, shift by doubling, add lower half
    task automatic set_reg(input int r, input logic [31:0] v);
        logic [15:0] lo;
        if (r == 0) return;
        run_addi(r, 0, v[31:16]);
        repeat (16) run_r(r, r, r, 6'h20);
        lo = v[15:0];
        run_addi(r, r, {1'b0, lo[15:1]});
        run_addi(r, r, {1'b0, lo[15:1]});
        run_addi(r, r, {15'd0, lo[0]});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        pc_m = 32'h0000_0000;
    endtask

    initial begin
        logic [31:0] v;
        logic [5:0]  fsel [6];

        vecs[0] = '{6'h20, 32'd5,          32'd7,          32'd12};
        vecs[1] = '{6'h22, 32'd5,          32'd7,          32'hFFFF_FFFE};
        vecs[2] = '{6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[3] = '{6'h20, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000};
        vecs[4] = '{6'h24, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234};
        vecs[5] = '{6'h25, 32'hF0F0_0000,  32'h0000_1234,  32'hF0F0_1234};
        vecs[6] = '{6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{6'h27, 32'd3,          32'd4,          32'd7};
        vecs[8] = '{6'h22, 32'd5,          32'd5,          32'd0};

        rst_n = 1'b0;
        idle();
        mem_rdata = 32'd0;
        model_reset();
        #12;
        check("rst_pc", pc_out, 32'h0000_0000);
        check("rst_opcode", {26'd0, Opcode}, 32'd0);
        check("rst_funct", {26'd0, Funct}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            read_reg(i, v);
            check("rst_reg", v, 32'd0);
        end
        MemWrite = 1'b1;
        #1 check("mem_we_follow", {31'd0, mem_we}, 32'd1);
        idle();

        // addi $8,$0,5 straight after reset: 4 cycles, PC ends at 4
        run_addi(8, 0, 16'd5);
        check("addi_pc", pc_out, 32'd4);
        read_reg(8, v);
        check("addi_r8", v, 32'd5);

        // ALU vector table through R-type add/sub/etc. into $10
        foreach (vecs[k]) begin
            set_reg(8, vecs[k].a);
            set_reg(9, vecs[k].b);
            run_r(10, 8, 9, vecs[k].funct);
            read_reg(10, v);
            check("vec_r10", v, vecs[k].exp);
        end

        // addi to $0 is discarded
        run_addi(0, 0, 16'd9);
        read_reg(0, v);
        check("r0_zero", v, 32'd0);

        // Read-during-write: add $10,$10,$10 reads old value on the writeback edge
        set_reg(10, 32'd12);
        run_r(10, 10, 10, 6'h20);
        check("rdw_old", mem_wdata, 32'd12);
        step();
        check("rdw_new", mem_wdata, 32'd24);

        // Randomized R-type ops against the model
        fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h24;
        fsel[3] = 6'h25; fsel[4] = 6'h2A; fsel[5] = 6'h00;
        for (int it = 0; it < 20; it++) begin
            int rs, rt, rd;
            logic [5:0] f;
            rs = $urandom_range(1, 31);
            rt = $urandom_range(1, 31);
            rd = $urandom_range(1, 31);
            f = fsel[$urandom_range(0, 5)];
            if (f == 6'h00) f = 6'($urandom_range(0, 63));
            set_reg(rs, $urandom);
            set_reg(rt, $urandom);
            run_r(rd, rs, rt, f);
            check_reg("rand_rd", rd);
            check_reg("rand_rs", rs);
        end

        // Reset asserted during exec of add $10,$8,$9
        set_reg(8, 32'd5);
        set_reg(9, 32'd7);
        fetch(32'h0109_5020);
        decode();
        ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = 2'b10;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pc", pc_out, 32'd0);
        check("midrst_opcode", {26'd0, Opcode}, 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        model_reset();
        idle();
        RegDst = 1'b1; RegWrite = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();
        check_reg("midrst_r10", 10);
        check_reg("midrst_r8", 8);
        check("midrst_pc_hold", pc_out, 32'd0);
        run_addi(8, 0, 16'd5);
        check("restart_pc", pc_out, 32'd4);
        check_reg("restart_r8", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
